// File: rtl/stack_writer.sv
// Write-side bus master: single-byte stores plus 1/2/3-byte stack pushes with SP update.
// Optional sticky SP-wrap flag output is enabled by defining STACK_WRITER_WRAP_FLAG_EN.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module stack_writer #(
  parameter int                    REG_WIDTH  = `REG_WIDTH,
  parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  wr_req,
  input  logic [1:0]            wr_mode,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0] wr_word,
  input  logic [REG_WIDTH-1:0]  sp_in,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_data,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  sp_out,
  output logic                  sp_we
`ifdef STACK_WRITER_WRAP_FLAG_EN
  , output logic                sp_wrap
`endif
);
  typedef enum logic [2:0] {IDLE, BYTE, PUSH_HI, PUSH_LO, PUSH_P} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  data_q, data_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [REG_WIDTH-1:0]  sp_q, sp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic                  spwe_q, spwe_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [REG_WIDTH-1:0]  mdata_q, mdata_d;
  logic [REG_WIDTH-1:0]  spout_q, spout_d;

  logic                  emit, emit_push, emit_last;
  logic [REG_WIDTH-1:0]  emit_data;
  logic [REG_WIDTH-1:0]  sp_dec;
  logic [ADDR_WIDTH-1:0] stack_addr;

  assign sp_dec     = sp_q - REG_WIDTH'(1);
  assign stack_addr = STACK_BASE | ADDR_WIDTH'(sp_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    data_d    = data_q;
    word_d    = word_q;
    sp_d      = sp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    spwe_d    = 1'b0;
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    spout_d   = spout_q;
    emit      = 1'b0;
    emit_push = 1'b0;
    emit_last = 1'b0;
    emit_data = data_q;

    // Busy stays up through the cycle of the final write, dropping one edge later.
    if (done_q) busy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_req && !busy_q) begin
          mode_d  = wr_mode;
          addr_d  = wr_addr;
          data_d  = wr_data;
          word_d  = wr_word;
          sp_d    = sp_in;
          busy_d  = 1'b1;
          state_d = wr_mode[1] ? PUSH_HI : BYTE;
        end
      end
      BYTE: begin
        emit      = 1'b1;
        emit_push = (mode_q == 2'd1);
        emit_last = 1'b1;
        emit_data = data_q;
      end
      PUSH_HI: begin
        emit      = 1'b1;
        emit_push = 1'b1;
        emit_data = word_q[ADDR_WIDTH-1 -: REG_WIDTH];
        state_d   = PUSH_LO;
      end
      PUSH_LO: begin
        emit      = 1'b1;
        emit_push = 1'b1;
        emit_data = word_q[REG_WIDTH-1:0];
        if (mode_q == 2'd3) state_d = PUSH_P;
        else                emit_last = 1'b1;
      end
      PUSH_P: begin
        emit      = 1'b1;
        emit_push = 1'b1;
        emit_last = 1'b1;
        emit_data = data_q;
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      we_d    = 1'b1;
      mdata_d = emit_data;
      maddr_d = emit_push ? stack_addr : addr_q;
      if (emit_push) sp_d = sp_dec;
      if (emit_last) begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (emit_push) begin
          spwe_d  = 1'b1;
          spout_d = sp_dec;
        end
      end
    end
  end

  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      word_q  <= '0;
      sp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      spwe_q  <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      spout_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      word_q  <= word_d;
      sp_q    <= sp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      spwe_q  <= spwe_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      spout_q <= spout_d;
    end
  end

  assign wr_busy  = busy_q;
  assign wr_done  = done_q;
  assign mem_we   = we_q;
  assign sp_we    = spwe_q;
  assign mem_addr = maddr_q;
  assign mem_data = mdata_q;
  assign sp_out   = spout_q;

`ifdef STACK_WRITER_WRAP_FLAG_EN
  // Pending bit delays the flag so it appears the cycle after the wrapping write.
  logic wrap_pend_q, wrap_pend_d;
  logic sp_wrap_q, sp_wrap_d;

  always_comb begin
    wrap_pend_d = emit && emit_push && (sp_q == '0);
    sp_wrap_d   = sp_wrap_q | wrap_pend_q;
  end

  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      wrap_pend_q <= 1'b0;
      sp_wrap_q   <= 1'b0;
    end else begin
      wrap_pend_q <= wrap_pend_d;
      sp_wrap_q   <= sp_wrap_d;
    end
  end

  assign sp_wrap = sp_wrap_q;
`endif

endmodule

// File: tb/tb_stack_writer.sv
// Directed + randomized self-checking bench for stack_writer against a queue-based write-list model.
`timescale 1ns/1ps

module tb_stack_writer;
  logic        phi1 = 1'b0;
  logic        reset_n;
  logic        wr_req;
  logic [1:0]  wr_mode;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] wr_word;
  logic [7:0]  sp_in;
  logic        wr_busy, wr_done, mem_we, sp_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, sp_out;
`ifdef STACK_WRITER_WRAP_FLAG_EN
  logic        sp_wrap;
`endif

  stack_writer dut (
    .phi1(phi1), .reset_n(reset_n), .wr_req(wr_req), .wr_mode(wr_mode),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_word(wr_word), .sp_in(sp_in),
    .wr_busy(wr_busy), .wr_done(wr_done), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .sp_out(sp_out), .sp_we(sp_we)
`ifdef STACK_WRITER_WRAP_FLAG_EN
    , .sp_wrap(sp_wrap)
`endif
  );

  always #5 phi1 = ~phi1;

  int checks = 0;
  int errors = 0;

  // Model state: expected bus writes for the current request and persistent outputs.
  logic [15:0] qa[$];
  logic [7:0]  qd[$];
  logic [7:0]  exp_sp_out = 8'h00;
  logic        exp_wrap   = 1'b0;
  logic [15:0] last_a     = 16'h0000;
  logic [7:0]  last_d     = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The write list follows directly from the mode: stores go to wr_addr,
  // pushes go to page 1 at descending SP, hi byte first.
  task automatic model(input logic [1:0] m, input logic [15:0] a, input logic [7:0] d,
                       input logic [15:0] w, input logic [7:0] sp);
    logic [7:0] bytes[$];
    qa.delete();
    qd.delete();
    if (m == 2'd0) begin
      qa.push_back(a);
      qd.push_back(d);
    end else begin
      if (m == 2'd1) bytes.push_back(d);
      else begin
        bytes.push_back(w[15:8]);
        bytes.push_back(w[7:0]);
        if (m == 2'd3) bytes.push_back(d);
      end
      for (int i = 0; i < bytes.size(); i++) begin
        qa.push_back(16'h0100 + 16'((int'(sp) - i) & 255));
        qd.push_back(bytes[i]);
      end
      if (int'(sp) < bytes.size()) exp_wrap = 1'b1;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, wr_busy, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_done"}, wr_done, 0);
    chk({tag, "_spwe"}, sp_we, 0);
    chk({tag, "_addr_hold"}, mem_addr, last_a);
    chk({tag, "_data_hold"}, mem_data, last_d);
    chk({tag, "_spout"}, sp_out, exp_sp_out);
`ifdef STACK_WRITER_WRAP_FLAG_EN
    chk({tag, "_wrap"}, sp_wrap, exp_wrap);
`endif
  endtask

  task automatic chk_writes(input string tag, input logic [1:0] m, input logic [7:0] prev_sp);
    int n;
    n = qa.size();
    for (int i = 0; i < n; i++) begin
      @(posedge phi1); #1;
      chk({tag, "_we"}, mem_we, 1);
      chk({tag, "_busy"}, wr_busy, 1);
      chk({tag, "_addr"}, mem_addr, qa[i]);
      chk({tag, "_data"}, mem_data, qd[i]);
      chk({tag, "_done"}, wr_done, (i == n - 1));
      chk({tag, "_spwe"}, sp_we, (i == n - 1) && (m != 2'd0));
      chk({tag, "_spout"}, sp_out, ((i == n - 1) && (m != 2'd0)) ? 8'(int'(prev_sp) - n) : exp_sp_out);
    end
    if (m != 2'd0) exp_sp_out = 8'(int'(prev_sp) - n);
    last_a = qa[n-1];
    last_d = qd[n-1];
  endtask

  // Issue one request from idle, scramble inputs after acceptance, check every cycle.
  task automatic do_req(input string tag, input logic [1:0] m, input logic [15:0] a,
                        input logic [7:0] d, input logic [15:0] w, input logic [7:0] sp);
    model(m, a, d, w, sp);
    wr_req = 1'b1; wr_mode = m; wr_addr = a; wr_data = d; wr_word = w; sp_in = sp;
    @(posedge phi1); #1;
    wr_req = 1'b0; wr_mode = 2'($urandom); wr_addr = 16'($urandom);
    wr_data = 8'($urandom); wr_word = 16'($urandom); sp_in = 8'($urandom);
    chk({tag, "_acc_busy"}, wr_busy, 1);
    chk({tag, "_acc_we"}, mem_we, 0);
    chk_writes(tag, m, sp);
    @(posedge phi1); #1;
    chk_idle({tag, "_post"});
  endtask

  task automatic chk_reset_vals(input string tag);
    last_a = 16'h0000; last_d = 8'h00; exp_sp_out = 8'h00; exp_wrap = 1'b0;
    chk_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m;
    logic [7:0]  sp;
    reset_n = 1'b0; wr_req = 1'b0; wr_mode = 2'd0; wr_addr = 16'h0;
    wr_data = 8'h0; wr_word = 16'h0; sp_in = 8'h0;
    repeat (2) @(posedge phi1);
    #1;
    chk_reset_vals("reset");
    reset_n = 1'b1;
    repeat (5) begin
      @(posedge phi1); #1;
      chk_idle("idle5");
    end

    do_req("store",   2'd0, 16'h0234, 8'hA5, 16'h0000, 8'h55);
    do_req("brk",     2'd3, 16'h0000, 8'h34, 16'hC123, 8'hFD);
    do_req("jsrwrap", 2'd2, 16'h0000, 8'h00, 16'h8001, 8'h00);
    do_req("pha",     2'd1, 16'h0000, 8'h7E, 16'h0000, 8'h80);

    // Reset during the second write of a 3-byte push aborts the rest.
    model(2'd3, 16'h0, 8'h99, 16'hBEEF, 8'h10);
    wr_req = 1'b1; wr_mode = 2'd3; wr_data = 8'h99; wr_word = 16'hBEEF; sp_in = 8'h10;
    @(posedge phi1); #1;
    wr_req = 1'b0;
    @(posedge phi1); #1;
    chk("abort_w1_addr", mem_addr, 16'h0110);
    @(posedge phi1); #1;
    chk("abort_w2_addr", mem_addr, 16'h010F);
    reset_n = 1'b0;
    @(posedge phi1); #1;
    chk_reset_vals("abort_rst");
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge phi1); #1;
      chk_idle("abort_after");
    end

    // Request held through busy and one cycle after: exactly one extra write.
    model(2'd1, 16'h0, 8'h3C, 16'h0, 8'hF0);
    wr_req = 1'b1; wr_mode = 2'd1; wr_data = 8'h3C; sp_in = 8'hF0;
    @(posedge phi1); #1;
    wr_mode = 2'd0; wr_addr = 16'h4321; wr_data = 8'h5A; sp_in = 8'h22;
    chk_writes("bub_pha", 2'd1, 8'hF0);
    @(posedge phi1); #1;
    chk_idle("bub_gap");
    @(posedge phi1); #1;
    wr_req = 1'b0;
    chk("bub_acc_busy", wr_busy, 1);
    chk("bub_acc_we", mem_we, 0);
    model(2'd0, 16'h4321, 8'h5A, 16'h0, 8'h22);
    chk_writes("bub_st", 2'd0, 8'h22);
    repeat (3) begin
      @(posedge phi1); #1;
      chk_idle("bub_tail");
    end

    for (int r = 0; r < 40; r++) begin
      m  = 2'($urandom);
      sp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      do_req("rnd", m, 16'($urandom), 8'($urandom), 16'($urandom), sp);
      repeat ($urandom_range(0, 2)) begin
        @(posedge phi1); #1;
        chk_idle("rnd_gap");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_writer.md
Name: stack_writer

Overview:
- Write-side counterpart to the instruction fetcher.
- The fetcher drives addresses and reads operand bytes. This block takes completed write requests from the execute stage and drives `mem_addr`, `mem_data` and `mem_we` onto the memory bus.
- It performs:
  - single-byte stores to an effective address;
  - single-byte stack pushes (PHA/PHP);
  - multi-byte frame pushes for JSR (PCH, PCL) and BRK/IRQ (PCH, PCL, P).
- It owns the stack-pointer update for those pushes.

Parameters:
- `REG_WIDTH`, default `` `REG_WIDTH `` (8): data/register width.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (16): bus address width.
- `STACK_BASE`, default 16'h0100: page base OR'd with SP for stack addresses.

Ports:
- `phi1` input 1: sole clock; all state updates on posedge `phi1`.
- `reset_n` input 1: synchronous, active-low reset.
- `wr_req` input 1: request valid; sampled only when `wr_busy`=0.
- `wr_mode` input 2:
  - 0 = store `wr_data` to `wr_addr`;
  - 1 = push `wr_data`;
  - 2 = push `wr_word` (hi, lo);
  - 3 = push `wr_word` hi, lo, then `wr_data` as P.
- `wr_addr` input `ADDR_WIDTH`: effective address, mode 0 only.
- `wr_data` input `REG_WIDTH`: byte for modes 0/1; status byte for mode 3.
- `wr_word` input `ADDR_WIDTH`: return PC for modes 2/3.
- `sp_in` input `REG_WIDTH`: current stack pointer, latched at accept.
- `wr_busy` output 1: high while a request is in progress.
- `wr_done` output 1: one-cycle pulse coincident with the final byte write.
- `mem_addr` output `ADDR_WIDTH`: bus address.
- `mem_data` output `REG_WIDTH`: bus write data.
- `mem_we` output 1: write strobe, one cycle per byte.
- `sp_out` output `REG_WIDTH`: updated stack pointer.
- `sp_we` output 1: one-cycle pulse, `sp_out` valid; pushes only.

Behaviour:
- Reset (`reset_n`=0 at posedge `phi1`):
  - state goes to IDLE;
  - `wr_busy`, `wr_done`, `mem_we` and `sp_we` = 0;
  - `mem_addr` = 0, `mem_data` = 0, `sp_out` = 0.
- Reset mid-request aborts the request:
  - no further `mem_we`, no `sp_done`/`sp_we` pulse;
  - bytes already written are not undone.
- States: IDLE, BYTE, PUSH_HI, PUSH_LO, PUSH_P.
- Accept:
  - In IDLE, `wr_req`=1 at edge k latches `wr_mode`, `wr_addr`, `wr_data`, `wr_word` and `sp_in`, and sets `wr_busy`=1 from edge k.
  - Inputs may change after edge k without effect.
- First write: `mem_we`=1 in cycle k+1, i.e. the registered outputs from edge k+1.
- One byte is written per cycle, with no gaps.
- Transitions:
  - mode 0: IDLE→BYTE, `mem_addr`=`wr_addr`;
  - mode 1: IDLE→BYTE, stack address;
  - mode 2: IDLE→PUSH_HI→PUSH_LO;
  - mode 3: IDLE→PUSH_HI→PUSH_LO→PUSH_P.
- Final write state → IDLE.
- Push address: `STACK_BASE` | {8'h00, sp}. SP decrements by 1 after each push byte and wraps 8'h00→8'hFF with no error.
- Push data:
  - PUSH_HI writes `wr_word[15:8]`;
  - PUSH_LO writes `wr_word[7:0]`;
  - PUSH_P and mode-1 BYTE write `wr_data`.
- Last-write cycle asserts together:
  - `wr_done`=1;
  - for modes 1–3, `sp_we`=1 with `sp_out` = latched SP − bytes pushed (mod 256).
- Mode 0 leaves `sp_we`=0 and `sp_out` unchanged.
- `wr_busy` falls in the cycle after the last write. A `wr_req` present then is accepted, so back-to-back requests have a 1-cycle bubble.
- `wr_req` while `wr_busy`=1 is ignored and is not queued.
- Latency from accept edge: `wr_done` at cycle k+1 (1 byte), k+2 (2 bytes) or k+3 (3 bytes).
- `mem_addr` and `mem_data` hold their last values when `mem_we`=0.

Optional Feature:
- Macro `STACK_WRITER_WRAP_FLAG_EN`.
- When defined:
  - adds output `sp_wrap` (1 bit);
  - `sp_wrap` is a sticky flag set when any push decrements SP from 8'h00 to 8'hFF;
  - cleared only by reset; visible from the cycle after the wrapping write.
- When undefined: the port is absent and wrap behaviour is otherwise identical.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, `wr_busy`=0, no `mem_we`.
- Mode 0, `wr_addr`=16'h0234, `wr_data`=8'hA5 → one cycle `mem_we`=1, `mem_addr`=0234, `mem_data`=A5, `wr_done`=1, `sp_we`=0; `wr_busy` drops next cycle.
- Mode 3, `sp_in`=8'hFD, `wr_word`=16'hC123, `wr_data`=8'h34 → writes in consecutive cycles:
  - 01FD←C1, 01FC←23, 01FB←34;
  - `wr_done` and `sp_we` on the third write, `sp_out`=8'hFA.
- Mode 2, `sp_in`=8'h00, `wr_word`=16'h8001 → writes 0100←80, 01FF←01; `sp_out`=8'hFE; `sp_wrap`=1 if `STACK_WRITER_WRAP_FLAG_EN`.
- Mode 3 accepted, `reset_n` low on the second write cycle → no third write, no `wr_done`/`sp_we`, outputs at reset values.
- Mode 1 push, with a second `wr_req` (mode 0) held high during busy and one cycle after → exactly one extra write, accepted at the cycle `wr_busy` is 0.
